// File: rtl/lsu_access_seq.sv
// lsu_access_seq: multi-cycle load/store sequencer between the core and a
// valid/ready data-memory bus.
//
// Takes one load/store (funct3 + byte address) and issues one or two aligned
// word transactions with byte masks. Load data is reassembled from the beat
// buffers and sign/zero-extended. The core is stalled until the DONE cycle.
//
// Build option: LSU_MISALIGN_SPLIT_EN
//   defined   - misaligned accesses are performed; word-crossing ones are
//               split into two beats (REQ1/RSP1).
//   undefined - an address that is not a multiple of the access size is
//               reported through o_err with no bus activity.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req/i_wren/i_funct3/i_addr/i_st_data   instruction side, sampled in IDLE
//   o_stall/o_done/o_err/o_ld_data           core handshake and load result
//   o_bus_*/i_bus_rdy     request channel (valid/ready)
//   i_bus_rvld/i_bus_rdata read response channel
module lsu_access_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_ld_data,
    output logic        o_bus_vld,
    input  logic        i_bus_rdy,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_wren,
    output logic [3:0]  o_bus_bmask,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_rvld,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        wren_q, wren_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  mask_q, mask_d;
    logic [63:0] wdata_q, wdata_d;
    logic [31:0] buf0_q, buf0_d;
    logic [31:0] buf1_q, buf1_d;
    logic        err_q, err_d;
    logic        cross_q, cross_d;

    // Request decode (only meaningful in IDLE)
    logic [1:0]  off;
    logic [2:0]  size;
    logic        legal_f3;
    logic        req_err;
    logic        req_cross;
    logic [3:0]  m4;
    logic [7:0]  m8;
    logic [31:0] st_trunc;
    logic [63:0] wide_wd;

    always_comb begin
        off  = i_addr[1:0];
        size = 3'd1 << i_funct3[1:0];
        if (i_wren)
            legal_f3 = !i_funct3[2] && (i_funct3[1:0] != 2'b11);
        else
            legal_f3 = (i_funct3[1:0] != 2'b11) && !(i_funct3[2] && i_funct3[1]);
`ifdef LSU_MISALIGN_SPLIT_EN
        req_err   = !legal_f3;
        req_cross = (3'({1'b0, off}) + size) > 3'd4;
`else
        // size 2 needs off[0]==0, size 4 needs off==0
        req_err   = !legal_f3 || (i_funct3[0] && off[0]) || (i_funct3[1] && (off != 2'b00));
        req_cross = 1'b0;
`endif
        m4 = 4'((5'd1 << size) - 5'd1);
        m8 = {4'b0000, m4} << off;
        case (i_funct3[1:0])
            2'b00:   st_trunc = {24'h0, i_st_data[7:0]};
            2'b01:   st_trunc = {16'h0, i_st_data[15:0]};
            default: st_trunc = i_st_data;
        endcase
        wide_wd = {32'h0, st_trunc} << {off, 3'b000};
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wren_d   = wren_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        err_d    = err_q;
        cross_d  = cross_q;
        case (state_q)
            IDLE: if (i_req) begin
                addr_d   = {i_addr[31:2], 2'b00};
                wren_d   = i_wren;
                funct3_d = i_funct3;
                off_d    = off;
                mask_d   = m8;
                wdata_d  = wide_wd;
                cross_d  = req_cross;
                err_d    = req_err;
                buf0_d   = 32'h0;
                buf1_d   = 32'h0;
                state_d  = req_err ? DONE : REQ0;
            end
            REQ0: if (i_bus_rdy)
                state_d = wren_q ? (cross_q ? REQ1 : DONE) : RSP0;
            RSP0: if (i_bus_rvld) begin
                buf0_d  = i_bus_rdata;
                state_d = cross_q ? REQ1 : DONE;
            end
            REQ1: if (i_bus_rdy)
                state_d = wren_q ? DONE : RSP1;
            RSP1: if (i_bus_rvld) begin
                buf1_d  = i_bus_rdata;
                state_d = DONE;
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wren_q   <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            mask_q   <= 8'h0;
            wdata_q  <= 64'h0;
            buf0_q   <= 32'h0;
            buf1_q   <= 32'h0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            err_q    <= err_d;
            cross_q  <= cross_d;
        end
    end

    // Outputs: all decoded from registered state, so an async reset clears
    // the bus request in the same cycle.
    logic        beat1;
    logic [63:0] shifted;
    logic [31:0] lo;
    logic        sx;
    logic [31:0] ext;

    always_comb begin
        beat1       = (state_q == REQ1);
        o_bus_vld   = (state_q == REQ0) || beat1;
        o_bus_addr  = o_bus_vld ? (beat1 ? addr_q + 32'd4 : addr_q) : 32'h0;
        o_bus_wren  = o_bus_vld && wren_q;
        o_bus_bmask = o_bus_vld ? (beat1 ? mask_q[7:4] : mask_q[3:0]) : 4'h0;
        o_bus_wdata = o_bus_vld ? (beat1 ? wdata_q[63:32] : wdata_q[31:0]) : 32'h0;

        // IDLE stall is combinational so the core holds on the request cycle
        o_stall = ((state_q == IDLE) && i_req && !i_reset) ||
                  (state_q == REQ0) || (state_q == RSP0) ||
                  (state_q == REQ1) || (state_q == RSP1);
        o_done  = (state_q == DONE);
        o_err   = o_done && err_q;

        shifted = {buf1_q, buf0_q} >> {off_q, 3'b000};
        lo      = shifted[31:0];
        sx      = !funct3_q[2];
        case (funct3_q[1:0])
            2'b00:   ext = {{24{sx && lo[7]}}, lo[7:0]};
            2'b01:   ext = {{16{sx && lo[15]}}, lo[15:0]};
            default: ext = lo;
        endcase
        o_ld_data = (o_done && !wren_q && !err_q) ? ext : 32'h0;
    end

endmodule
